// File: rtl/mac_pkg.sv
// mac_pkg: shared types, width helper and default clamp constants for the MAC array.
package mac_pkg;
    typedef enum logic {SAT_WRAP = 1'b0, SAT_CLAMP = 1'b1} sat_mode_t;

    function automatic int z_w(input int a_w, input int guard);
        return 2 * a_w + guard;
    endfunction

    localparam int A_W_DEF = 10;
    localparam int GUARD_DEF = 2;
    localparam int Z_W_DEF = z_w(A_W_DEF, GUARD_DEF);
    localparam logic [Z_W_DEF-1:0] Z_MAX_DEF = {1'b0, {(Z_W_DEF-1){1'b1}}};
    localparam logic [Z_W_DEF-1:0] Z_MIN_DEF = {1'b1, {(Z_W_DEF-1){1'b0}}};
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one signed MAC lane -- operand register, product register, accumulator
// with overflow detection, optional clamping and a sticky per-accumulation overflow flag.
module mac_lane
    import mac_pkg::*;
#(
    parameter int        A_W   = 10,
    parameter int        GUARD = 2,
    parameter sat_mode_t MODE  = SAT_CLAMP
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic signed [A_W-1:0]             a,
    input  logic signed [A_W-1:0]             b,
    input  logic                              p_valid,
    input  logic                              p_first,
    input  logic                              p_last,
    output logic signed [z_w(A_W,GUARD)-1:0]  z,
    output logic                              ovf
);
    localparam int Z_W = z_w(A_W, GUARD);
    localparam int P_W = 2 * A_W;
    localparam logic [Z_W-1:0] Z_MAX = {1'b0, {(Z_W-1){1'b1}}};
    localparam logic [Z_W-1:0] Z_MIN = {1'b1, {(Z_W-1){1'b0}}};

    logic signed [A_W-1:0] a_r, b_r;
    logic signed [P_W-1:0] p;
    logic signed [Z_W-1:0] acc, nxt;
    logic signed [Z_W:0]   sum;
    logic                  sticky, of;

    // One extra bit of headroom: the top two bits disagree exactly when Z_W overflows.
    always_comb begin
        sum = (p_first ? (Z_W+1)'(0) : (Z_W+1)'(acc)) + (Z_W+1)'(p);
        of  = sum[Z_W] ^ sum[Z_W-1];
        nxt = (of && MODE == SAT_CLAMP) ? (sum[Z_W] ? Z_MIN : Z_MAX) : sum[Z_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            p      <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            z      <= '0;
            ovf    <= 1'b0;
        end else if (en) begin
            a_r <= a;
            b_r <= b;
            p   <= a_r * b_r;
            if (p_valid) begin
                acc    <= nxt;
                sticky <= (p_first ? 1'b0 : sticky) | of;
                if (p_last) begin
                    z   <= nxt;
                    ovf <= (p_first ? 1'b0 : sticky) | of;
                end
            end
        end
    end
endmodule

// File: rtl/mac_array_n.sv
// mac_array_n: LANES-wide signed multiply-accumulate engine; shared beat counter,
// valid pipeline and stall control drive one mac_lane per lane.
module mac_array_n
    import mac_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int A_W      = 10,
    parameter int GUARD    = 2,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*A_W-1:0]                 a,
    input  logic [LANES*A_W-1:0]                 b,
    input  logic [CNT_W-1:0]                     acc_len,
    output logic                                 z_valid,
    input  logic                                 out_ready,
    output logic [LANES*z_w(A_W,GUARD)-1:0]      z,
    output logic [LANES-1:0]                     ovf
);
    localparam int Z_W = z_w(A_W, GUARD);

    logic             rdy, stall, fire, first, last;
    logic [CNT_W-1:0] cnt, len, eff_len;
    logic             s_valid, s_first, s_last;
    logic             p_valid, p_first, p_last;

    assign stall    = z_valid && !out_ready;
    assign in_ready = rdy && !stall;
    assign fire     = in_valid && in_ready;

    // acc_len is only honoured on the first beat; later beats use the latched length.
    always_comb begin
        first   = cnt == '0;
        eff_len = !first ? len : (acc_len == '0 ? CNT_W'(1) : acc_len);
        last    = cnt == eff_len - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy     <= 1'b0;
            cnt     <= '0;
            len     <= '0;
            s_valid <= 1'b0;
            s_first <= 1'b0;
            s_last  <= 1'b0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            z_valid <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (fire) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (first) len <= eff_len;
            end
            // Without a stall any pending result is being taken, so z_valid just follows p_last.
            if (!stall) begin
                s_valid <= fire;
                s_first <= fire && first;
                s_last  <= fire && last;
                p_valid <= s_valid;
                p_first <= s_first;
                p_last  <= s_last;
                z_valid <= p_valid && p_last;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .A_W  (A_W),
            .GUARD(GUARD),
            .MODE (SATURATE != 0 ? SAT_CLAMP : SAT_WRAP)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (!stall),
            .a      (a[i*A_W +: A_W]),
            .b      (b[i*A_W +: A_W]),
            .p_valid(p_valid),
            .p_first(p_first),
            .p_last (p_last),
            .z      (z[i*Z_W +: Z_W]),
            .ovf    (ovf[i])
        );
    end
endmodule

// File: tb/tb_mac_array_n.sv
// tb_mac_array_n: directed checks of the MAC array in clamp and wrap modes side by side.
module tb_mac_array_n;
    logic        clk, rst, in_valid, out_ready;
    logic [39:0] a, b;
    logic [7:0]  acc_len;
    logic        in_ready_s, in_ready_w, zv_s, zv_w;
    logic [87:0] z_s, z_w;
    logic [3:0]  ovf_s, ovf_w;
    int          vectors = 0, miscompares = 0;
    int          idx, got, stall_cnt;
    logic        prev_r;

    mac_array_n #(.SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
        .acc_len(acc_len), .z_valid(zv_s), .out_ready(out_ready), .z(z_s), .ovf(ovf_s));
    mac_array_n #(.SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
        .acc_len(acc_len), .z_valid(zv_w), .out_ready(out_ready), .z(z_w), .ovf(ovf_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] arep(input int v);
        logic [9:0] t;
        t = v[9:0];
        return {4{t}};
    endfunction

    function automatic logic [87:0] zrep(input int v);
        logic [21:0] t;
        t = v[21:0];
        return {4{t}};
    endfunction

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input int av, input int bv, input int len);
        in_valid = 1'b1;
        a = arep(av);
        b = arep(bv);
        acc_len = len[7:0];
        @(negedge clk);
    endtask

    // Called right after the last beat's edge: result must appear exactly two edges later.
    task automatic expect_res(input string tag, input int zs, input logic [3:0] os,
                              input int zw, input logic [3:0] ow);
        in_valid = 1'b0;
        chk({tag, "_lat0"}, 88'(zv_s), 88'(0));
        @(negedge clk);
        chk({tag, "_lat1"}, 88'(zv_s), 88'(0));
        @(negedge clk);
        chk({tag, "_zv_s"}, 88'(zv_s), 88'(1));
        chk({tag, "_z_s"}, z_s, zrep(zs));
        chk({tag, "_ovf_s"}, 88'(ovf_s), 88'(os));
        chk({tag, "_zv_w"}, 88'(zv_w), 88'(1));
        chk({tag, "_z_w"}, z_w, zrep(zw));
        chk({tag, "_ovf_w"}, 88'(ovf_w), 88'(ow));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; acc_len = 8'd1;
        #1;
        chk("rst_in_ready", 88'(in_ready_s), 88'(0));
        chk("rst_zv", 88'(zv_s), 88'(0));
        chk("rst_z", z_s, 88'(0));
        chk("rst_ovf", 88'(ovf_s), 88'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 88'(in_ready_s), 88'(1));

        // basic 4-beat accumulation: 2*(1+2+3+4)
        send(1, 2, 4); send(2, 2, 4); send(3, 2, 4); send(4, 2, 4);
        expect_res("t1", 20, 4'h0, 20, 4'h0);
        @(negedge clk);
        chk("t1_pulse", 88'(zv_s), 88'(0));

        // len=1 streaming, one result per cycle
        acc_len = 8'd1;
        for (int i = 0; i < 13; i++) begin
            chk("t2_in_ready", 88'(in_ready_s), 88'(1));
            if (i >= 3) begin
                chk("t2_zv", 88'(zv_s), 88'(1));
                chk("t2_z", z_s, zrep(-(i - 3)));
            end
            if (i < 10) begin
                in_valid = 1'b1; a = arep(i); b = arep(-1);
            end else in_valid = 1'b0;
            @(negedge clk);
        end
        chk("t2_zv_end", 88'(zv_s), 88'(0));

        // overflow: 8 * 2^18 = 2^21 just past +max
        for (int i = 0; i < 8; i++) send(-512, -512, 8);
        expect_res("t3", (1 << 21) - 1, 4'hF, -(1 << 21), 4'hF);
        @(negedge clk);
        chk("t3_clear", 88'(zv_s), 88'(0));

        // backpressure: results 1..6, five stall cycles on the first
        out_ready = 1'b0; acc_len = 8'd1; idx = 1; got = 1; stall_cnt = 0;
        in_valid = 1'b1; a = arep(1); b = arep(1);
        #1;
        prev_r = in_ready_s && in_valid;
        for (int c = 0; c < 60 && got <= 6; c++) begin
            @(negedge clk);
            if (prev_r) begin
                idx++;
                if (idx > 6) in_valid = 1'b0;
                else a = arep(idx);
            end
            if (zv_s && !out_ready) begin
                stall_cnt++;
                chk("t4_stall_rdy", 88'(in_ready_s), 88'(0));
                chk("t4_stall_z", z_s, zrep(1));
                if (stall_cnt == 5) out_ready = 1'b1;
            end
            #1;
            prev_r = in_ready_s && in_valid;
            if (zv_s && out_ready) begin
                chk("t4_z", z_s, zrep(got));
                got++;
            end
        end
        chk("t4_count", 88'(got), 88'(7));
        chk("t4_stalls", 88'(stall_cnt), 88'(5));
        in_valid = 1'b0;
        @(negedge clk);

        // reset mid-accumulation discards the partial sum
        send(5, 5, 4); send(5, 5, 4);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("t5_rst_rdy", 88'(in_ready_s), 88'(0));
        chk("t5_rst_zv", 88'(zv_s), 88'(0));
        chk("t5_rst_z", z_s, 88'(0));
        chk("t5_rst_ovf", 88'(ovf_s), 88'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rdy", 88'(in_ready_s), 88'(1));
        for (int i = 0; i < 4; i++) send(1, 1, 4);
        expect_res("t5", 4, 4'h0, 4, 4'h0);

        // acc_len change mid-accumulation only takes effect next time
        send(1, 1, 4); send(1, 1, 2); send(1, 1, 2); send(1, 1, 2);
        expect_res("t6a", 4, 4'h0, 4, 4'h0);
        send(3, 1, 2); send(3, 1, 2);
        expect_res("t6b", 6, 4'h0, 6, 4'h0);

        // acc_len=0 behaves as 1
        send(7, 1, 0);
        expect_res("t7", 7, 4'h0, 7, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
